// File: rtl/alu_sequencer.sv
// Control sequencer for the ALU datapath: start/busy handshake, multiplier run/count, HiLo write strobe, output mux select.
// Optional macro ALU_SEQ_ILLEGAL_EN adds an 'illegal' flag pulsed with done for unrecognised codes.
module alu_sequencer #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  output logic             busy,
  output logic             done,
  output logic [5:0]       mux_sel,
  output logic [5:0]       alu_sel,
  output logic             mul_run,
  output logic [CNT_W-1:0] mul_cnt,
  output logic             hilo_we
`ifdef ALU_SEQ_ILLEGAL_EN
  ,
  output logic             illegal
`endif
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

  function automatic logic is_alu(input logic [5:0] f);
    return (f == F_AND) || (f == F_OR) || (f == F_ADD) || (f == F_SUB) || (f == F_SLT);
  endfunction

  function automatic logic is_legal(input logic [5:0] f);
    return is_alu(f) || (f == F_SRL) || (f == F_MULTU) || (f == F_MFHI) || (f == F_MFLO);
  endfunction

  state_t           state_q, state_d;
  logic [5:0]       mux_q, mux_d;
  logic [5:0]       alu_q, alu_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mux_q   <= '0;
      alu_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mux_q   <= mux_d;
      alu_q   <= alu_d;
      cnt_q   <= cnt_d;
    end
  end

  // Selects are loaded on accept so they are valid from the first EXEC/MUL cycle and hold through IDLE.
  always_comb begin
    state_d = state_q;
    mux_d   = mux_q;
    alu_d   = alu_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (Signal == F_MULTU) begin
            state_d = S_MUL;
            cnt_d   = '0;
            mux_d   = '0;
            alu_d   = '0;
          end else begin
            state_d = S_EXEC;
            mux_d   = is_legal(Signal) ? Signal : 6'b0;
            alu_d   = is_alu(Signal)   ? Signal : 6'b0;
          end
        end
      end
      S_EXEC: state_d = S_IDLE;
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_EXEC) || (state_q == S_WB);
  assign mul_run = (state_q == S_MUL);
  assign hilo_we = (state_q == S_WB);
  assign mux_sel = mux_q;
  assign alu_sel = alu_q;
  assign mul_cnt = cnt_q;

`ifdef ALU_SEQ_ILLEGAL_EN
  logic [5:0] op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          op_q <= '0;
    else if ((state_q == S_IDLE) && start) op_q <= Signal;
  end

  assign illegal = (state_q == S_EXEC) && !is_legal(op_q);
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: countdown model of the handshake checked every cycle, plus directed literal checks.
module tb_alu_sequencer;
  localparam int MUL_CYCLES = 32;
  localparam int CNT_W      = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [5:0] Signal = 6'b0;
  logic busy, done, mul_run, hilo_we;
  logic [5:0] mux_sel, alu_sel;
  logic [CNT_W-1:0] mul_cnt;
`ifdef ALU_SEQ_ILLEGAL_EN
  logic illegal;
`endif

  alu_sequencer #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal),
    .busy(busy), .done(done), .mux_sel(mux_sel), .alu_sel(alu_sel),
    .mul_run(mul_run), .mul_cnt(mul_cnt), .hilo_we(hilo_we)
`ifdef ALU_SEQ_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_alu(input logic [5:0] f);
    return f inside {6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
  endfunction
  function automatic bit f_legal(input logic [5:0] f);
    return f_alu(f) || (f inside {6'b000010, 6'b011001, 6'b010000, 6'b010010});
  endfunction

  // Model: 'left' = busy cycles still to come; the last one is the done cycle.
  int         left = 0;
  bit         m_mul = 0, m_ill = 0;
  logic [5:0] m_mux = 0, m_alu = 0;

  always @(negedge clk) begin
    if (reset) begin
      left = 0; m_mul = 0; m_ill = 0; m_mux = 0; m_alu = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mul_run", mul_run, 0);
      chk("rst_hilo_we", hilo_we, 0);
      chk("rst_mux_sel", mux_sel, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_mul_cnt", mul_cnt, 0);
    end else begin
      chk("m_busy", busy, int'(left > 0));
      chk("m_done", done, int'(left == 1));
      chk("m_mul_run", mul_run, int'(m_mul && left > 1));
      chk("m_mul_cnt", mul_cnt, (m_mul && left > 1) ? MUL_CYCLES + 1 - left : 0);
      chk("m_hilo_we", hilo_we, int'(m_mul && left == 1));
      chk("m_mux_sel", mux_sel, m_mux);
      chk("m_alu_sel", alu_sel, m_alu);
`ifdef ALU_SEQ_ILLEGAL_EN
      chk("m_illegal", illegal, int'(m_ill && left == 1));
`endif
      if (left > 0) left--;
      else if (start) begin
        m_mul = (Signal == 6'b011001);
        m_ill = !f_legal(Signal);
        left  = m_mul ? MUL_CYCLES + 1 : 1;
        m_mux = (m_mul || m_ill) ? 6'b0 : Signal;
        m_alu = f_alu(Signal) ? Signal : 6'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [5:0] code);
    start = 1'b1; Signal = code;
    cyc();
    start = 1'b0; Signal = 6'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin cyc(); n++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  logic [5:0] ops [6] = '{6'b100100, 6'b100101, 6'b100010, 6'b101010, 6'b010010, 6'b000010};

  initial begin
    int n, runs, hw;
    cyc(); cyc();
    reset = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_mux", mux_sel, 0);
    cyc();

    issue(6'b100000);
    chk("add_done", done, 1);
    chk("add_mux", mux_sel, 6'b100000);
    chk("add_alu", alu_sel, 6'b100000);
    cyc();
    chk("add_busy_after", busy, 0);
    chk("add_mux_hold", mux_sel, 6'b100000);
    cyc();

    issue(6'b011001);
    n = 1; runs = 0;
    while (!done && n < 100) begin runs += int'(mul_run); cyc(); n++; end
    chk("mul_latency", n, 33);
    chk("mul_runs", runs, 32);
    chk("mul_hilo_we", hilo_we, 1);
    chk("mul_mux_zero", mux_sel, 0);
    cyc();
    chk("mul_idle", busy, 0);

    issue(6'b011001);
    cyc(); cyc(); cyc();
    issue(6'b010000);
    wait_done(n);
    cyc();
    issue(6'b010000);
    chk("mfhi_done", done, 1);
    chk("mfhi_mux", mux_sel, 6'b010000);
    chk("mfhi_alu", alu_sel, 0);
    cyc();

    issue(6'b011001);
    n = 0;
    while (mul_cnt != 6'd10 && n < 100) begin cyc(); n++; end
    chk("reached_cnt10", mul_cnt, 10);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_run", mul_run, 0);
    chk("abort_cnt", mul_cnt, 0);
    cyc();
    reset = 1'b0;
    hw = 0;
    repeat (40) begin hw += int'(hilo_we); cyc(); end
    chk("abort_no_hilo_we", hw, 0);
    issue(6'b000010);
    chk("srl_done", done, 1);
    chk("srl_mux", mux_sel, 6'b000010);
    chk("srl_alu", alu_sel, 0);
    cyc();

    issue(6'b111111);
    chk("ill_done", done, 1);
    chk("ill_mux", mux_sel, 0);
`ifdef ALU_SEQ_ILLEGAL_EN
    chk("ill_flag", illegal, 1);
`endif
    cyc();

    foreach (ops[i]) begin
      issue(ops[i]);
      chk("op_done", done, 1);
      cyc();
    end
    issue(6'b000001);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
